// File: rtl/sat_pkg.sv
// Shared definitions for the SAT solver datapath: FAT geometry, requester
// ids, assignment encoding, arbiter state type and small one-hot helpers.
package sat_pkg;

    localparam int VAR_NUM     = 8;
    localparam int VAR_NUM_LOG = 3;

    // Requester ids, also the bit positions in req/gnt/rvalid
    localparam logic [1:0] REQ_BT  = 2'd0;
    localparam logic [1:0] REQ_IMP = 2'd1;
    localparam logic [1:0] REQ_DEC = 2'd2;

    // Two-bit variable assignment encoding stored in the FAT
    localparam logic [1:0] ASSIGN_UNASSIGNED = 2'b00;
    localparam logic [1:0] ASSIGN_FALSE      = 2'b01;
    localparam logic [1:0] ASSIGN_TRUE       = 2'b10;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    // Index of the set bit of a one-hot requester vector (0 when none set)
    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        logic [1:0] id;
        case (oh)
            3'b001:  id = REQ_BT;
            3'b010:  id = REQ_IMP;
            3'b100:  id = REQ_DEC;
            default: id = 2'd0;
        endcase
        return id;
    endfunction

    // One-hot requester vector for an id (all zero for an invalid id)
    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        logic [2:0] oh;
        case (id)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fat_access_arbiter_if.sv
// Requester-side and FAT-side signals of the FAT access arbiter.
// The slave modport is the arbiter; the master modport is the environment
// (requesters plus the FAT memory).
interface fat_access_arbiter_if;
    import sat_pkg::*;

    logic [2:0]               req;
    logic [2:0]               req_write;
    logic [2:0]               req_lock;
    logic [3*VAR_NUM_LOG-1:0] req_addr;
    logic [3*2-1:0]           req_wdata;
    logic [2:0]               gnt;
    logic [2:0]               rvalid;
    logic [1:0]               rdata;
    logic                     busy;
    logic                     fat_enable;
    logic                     fat_write;
    logic [VAR_NUM_LOG-1:0]   fat_addr;
    logic [1:0]               fat_wdata;
    logic [1:0]               fat_rdata;

    modport master (
        output req, req_write, req_lock, req_addr, req_wdata, fat_rdata,
        input  gnt, rvalid, rdata, busy, fat_enable, fat_write, fat_addr, fat_wdata
    );

    modport slave (
        input  req, req_write, req_lock, req_addr, req_wdata, fat_rdata,
        output gnt, rvalid, rdata, busy, fat_enable, fat_write, fat_addr, fat_wdata
    );

endinterface

// File: rtl/fat_req_selector.sv
// Combinational winner selection for the FAT arbiter. While a lock is held
// only the owner can win; otherwise backtrack beats everything, a boosted
// decision unit beats implication, then implication, then decision.
module fat_req_selector
    import sat_pkg::*;
(
    input  logic [2:0] req,
    input  logic       boost,
    input  logic       lock_valid,
    input  logic [1:0] lock_owner,
    output logic [2:0] gnt
);

    // Pick a single winner from the current requests
    always_comb begin
        gnt = 3'b000;
        if (lock_valid) begin
            gnt = id_to_onehot(lock_owner) & req;
        end else if (req[REQ_BT]) begin
            gnt = 3'b001;
        end else if (boost && req[REQ_DEC]) begin
            gnt = 3'b100;
        end else if (req[REQ_IMP]) begin
            gnt = 3'b010;
        end else if (req[REQ_DEC]) begin
            gnt = 3'b100;
        end else begin
            gnt = 3'b000;
        end
    end

endmodule

// File: rtl/fat_access_arbiter.sv
// Arbiter sharing the single-port FAT among backtrack, implication and
// decision units. Holds the burst lock FSM, the decision-unit starvation
// counter, the FAT request mux and the one-cycle read-return pipeline.
module fat_access_arbiter
    import sat_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fat_access_arbiter_if.slave  bus
);

    localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_r;
    arb_state_e       state_s;
    logic [1:0]       owner_r;
    logic [1:0]       owner_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_s;
    logic [2:0]       rvalid_r;
    logic [2:0]       sel_gnt_s;
    logic [2:0]       gnt_s;
    logic [1:0]       win_id_s;
    logic             boost_s;
    logic             lock_valid_s;

    assign boost_s      = (starve_cnt_r == STARVE_MAX);
    assign lock_valid_s = (state_r == LOCKED);

    fat_req_selector u_sel (
        .req        (bus.req),
        .boost      (boost_s),
        .lock_valid (lock_valid_s),
        .lock_owner (owner_r),
        .gnt        (sel_gnt_s)
    );

    // Suppress grants while reset is asserted so outputs drop immediately
    always_comb begin
        gnt_s = 3'b000;
        if (rst) begin
            gnt_s = 3'b000;
        end else begin
            gnt_s = sel_gnt_s;
        end
    end

    assign win_id_s = onehot_to_id(gnt_s);

    // Route the winning requester's access onto the FAT port, zero when idle
    always_comb begin
        bus.fat_write = 1'b0;
        bus.fat_addr  = {VAR_NUM_LOG{1'b0}};
        bus.fat_wdata = 2'b00;
        case (gnt_s)
            3'b001: begin
                bus.fat_write = bus.req_write[0];
                bus.fat_addr  = bus.req_addr[0*VAR_NUM_LOG +: VAR_NUM_LOG];
                bus.fat_wdata = bus.req_wdata[1:0];
            end
            3'b010: begin
                bus.fat_write = bus.req_write[1];
                bus.fat_addr  = bus.req_addr[1*VAR_NUM_LOG +: VAR_NUM_LOG];
                bus.fat_wdata = bus.req_wdata[3:2];
            end
            3'b100: begin
                bus.fat_write = bus.req_write[2];
                bus.fat_addr  = bus.req_addr[2*VAR_NUM_LOG +: VAR_NUM_LOG];
                bus.fat_wdata = bus.req_wdata[5:4];
            end
            default: begin
                bus.fat_write = 1'b0;
                bus.fat_addr  = {VAR_NUM_LOG{1'b0}};
                bus.fat_wdata = 2'b00;
            end
        endcase
    end

    // Lock FSM next state: enter on a locked grant, leave on the last burst
    // access or when the owner abandons (drops both req and lock)
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        case (state_r)
            UNLOCKED: begin
                if ((|gnt_s) && bus.req_lock[win_id_s]) begin
                    state_s = LOCKED;
                    owner_s = win_id_s;
                end else begin
                    state_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (gnt_s[owner_r] && !bus.req_lock[owner_r]) begin
                    state_s = UNLOCKED;
                end else if (!bus.req[owner_r] && !bus.req_lock[owner_r]) begin
                    state_s = UNLOCKED;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s = UNLOCKED;
                owner_s = 2'd0;
            end
        endcase
    end

    // Starvation counter: saturating count of cycles the decision unit waits
    always_comb begin
        starve_cnt_s = {CNT_W{1'b0}};
        if (bus.req[REQ_DEC] && !gnt_s[REQ_DEC]) begin
            if (starve_cnt_r == STARVE_MAX) begin
                starve_cnt_s = STARVE_MAX;
            end else begin
                starve_cnt_s = starve_cnt_r + CNT_W'(1);
            end
        end else begin
            starve_cnt_s = {CNT_W{1'b0}};
        end
    end

    // State, owner, starvation counter and read-return strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= UNLOCKED;
            owner_r      <= 2'd0;
            starve_cnt_r <= {CNT_W{1'b0}};
            rvalid_r     <= 3'b000;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            starve_cnt_r <= starve_cnt_s;
            rvalid_r     <= gnt_s & ~bus.req_write;
        end
    end

    // The FAT presents read data in the cycle after the access, which is
    // exactly when rvalid_r is up, so rdata forwards it gated by rvalid
    assign bus.rdata      = (|rvalid_r) ? bus.fat_rdata : 2'b00;
    assign bus.rvalid     = rvalid_r;
    assign bus.gnt        = gnt_s;
    assign bus.busy       = (state_r == LOCKED);
    assign bus.fat_enable = |gnt_s;

endmodule

// File: tb/tb_fat_access_arbiter.sv
// Self-checking bench for fat_access_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_fat_access_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst;

    fat_access_arbiter_if bus ();

    fat_access_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FAT memory: single port, synchronous read
    logic [1:0] fat_mem [0:7];
    always @(posedge clk) begin
        if (bus.fat_enable) begin
            if (bus.fat_write) fat_mem[bus.fat_addr] <= bus.fat_wdata;
            else               bus.fat_rdata <= fat_mem[bus.fat_addr];
        end
    end

    // Reference model state
    bit         m_locked;
    int         m_owner;
    int         m_starve;
    logic [2:0] m_rvalid;
    logic [1:0] m_rdata;
    logic [1:0] ref_mem [0:7];

    int n_checks;
    int n_pass;
    logic [2:0] last_gnt;
    logic       last_busy;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Who should be served this cycle according to the arbitration rules
    function automatic logic [2:0] exp_gnt();
        logic [2:0] g;
        g = 3'b000;
        if (m_locked) g[m_owner] = bus.req[m_owner];
        else if (bus.req[0]) g = 3'b001;
        else if (m_starve == LIMIT && bus.req[2]) g = 3'b100;
        else if (bus.req[1]) g = 3'b010;
        else if (bus.req[2]) g = 3'b100;
        return g;
    endfunction

    function automatic int winner(input logic [2:0] g);
        int w;
        w = 0;
        for (int i = 0; i < 3; i++) if (g[i]) w = i;
        return w;
    endfunction

    task automatic check_all();
        logic [2:0] g;
        int w;
        bit any;
        g = exp_gnt();
        w = winner(g);
        any = (g != 3'b000);
        last_gnt  = bus.gnt;
        last_busy = bus.busy;
        check_eq("gnt", 32'(bus.gnt), 32'(g));
        check_eq("busy", 32'(bus.busy), 32'(m_locked));
        check_eq("fat_enable", 32'(bus.fat_enable), 32'(any));
        check_eq("fat_write", 32'(bus.fat_write), any ? 32'(bus.req_write[w]) : 32'd0);
        check_eq("fat_addr", 32'(bus.fat_addr), any ? 32'(bus.req_addr[w*3 +: 3]) : 32'd0);
        check_eq("fat_wdata", 32'(bus.fat_wdata), any ? 32'(bus.req_wdata[w*2 +: 2]) : 32'd0);
        check_eq("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        if (m_rvalid != 3'b000) check_eq("rdata", 32'(bus.rdata), 32'(m_rdata));
    endtask

    // Advance the model across one clock edge
    task automatic model_update();
        logic [2:0] g;
        int w;
        int a;
        g = exp_gnt();
        w = winner(g);
        a = int'(bus.req_addr[w*3 +: 3]);
        m_rvalid = 3'b000;
        if (g != 3'b000) begin
            if (bus.req_write[w]) ref_mem[a] = bus.req_wdata[w*2 +: 2];
            else begin
                m_rvalid = g;
                m_rdata  = ref_mem[a];
            end
        end
        if (bus.req[2] && !g[2]) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
        else m_starve = 0;
        if (!m_locked) begin
            if (g != 3'b000 && bus.req_lock[w]) begin
                m_locked = 1'b1;
                m_owner  = w;
            end
        end else if ((g[m_owner] && !bus.req_lock[m_owner]) ||
                     (!bus.req[m_owner] && !bus.req_lock[m_owner])) begin
            m_locked = 1'b0;
        end
    endtask

    function automatic logic [8:0] pack_a(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        return {a2, a1, a0};
    endfunction

    // One bus cycle: entered and left just after a rising edge
    task automatic cycle(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                         input logic [8:0] a, input logic [5:0] d);
        bus.req       = r;
        bus.req_write = w;
        bus.req_lock  = l;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_starve = 0;
        m_rvalid = 3'b000;
        m_rdata  = 2'b00;
    endtask

    logic [2:0] gexp [0:4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            fat_mem[i] = 2'($urandom);
            ref_mem[i] = fat_mem[i];
        end
        bus.fat_rdata = 2'b00;
        bus.req = 3'b000; bus.req_write = 3'b000; bus.req_lock = 3'b000;
        bus.req_addr = 9'd0; bus.req_wdata = 6'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_fat_enable", 32'(bus.fat_enable), 32'd0);
        check_eq("rst_fat_write", 32'(bus.fat_write), 32'd0);
        check_eq("rst_fat_addr", 32'(bus.fat_addr), 32'd0);
        check_eq("rst_fat_wdata", 32'(bus.fat_wdata), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All three read at once: backtrack wins, data returns next cycle
        cycle(3'b111, 3'b000, 3'b000, pack_a(3'd1, 3'd2, 3'd3), 6'd0);
        check_eq("all3_gnt", 32'(last_gnt), 32'b001);
        check_eq("all3_rvalid", 32'(bus.rvalid), 32'b001);
        check_eq("all3_rdata", 32'(bus.rdata), 32'(ref_mem[1]));

        // Backtrack un-assign sweep under lock with implication waiting
        for (int i = 0; i < 4; i++) begin
            cycle(3'b011, 3'b001, (i < 3) ? 3'b001 : 3'b000, pack_a(3'(4 + i), 3'd0, 3'd0), 6'd0);
            check_eq("burst_gnt", 32'(last_gnt), 32'b001);
            check_eq("burst_busy", 32'(last_busy), (i == 0) ? 32'd0 : 32'd1);
        end
        cycle(3'b010, 3'b000, 3'b000, pack_a(3'd0, 3'd5, 3'd0), 6'd0);
        check_eq("burst_after_gnt", 32'(last_gnt), 32'b010);
        check_eq("burst_after_busy", 32'(last_busy), 32'd0);
        for (int i = 4; i < 8; i++) check_eq("burst_mem", 32'(fat_mem[i]), 32'd0);

        // Starvation boost of the decision unit
        gexp[0] = 3'b010; gexp[1] = 3'b010; gexp[2] = 3'b010; gexp[3] = 3'b010; gexp[4] = 3'b100;
        for (int i = 0; i < 5; i++) begin
            cycle(3'b110, 3'b000, 3'b000, pack_a(3'd0, 3'd2, 3'd6), 6'd0);
            check_eq("starve_gnt", 32'(last_gnt), 32'(gexp[i]));
        end
        cycle(3'b110, 3'b000, 3'b000, pack_a(3'd0, 3'd2, 3'd6), 6'd0);
        check_eq("starve_clear_gnt", 32'(last_gnt), 32'b010);

        // Lock abandon by the implication unit
        cycle(3'b010, 3'b010, 3'b010, pack_a(3'd0, 3'd3, 3'd0), 6'b00_10_00);
        check_eq("abandon_first", 32'(last_gnt), 32'b010);
        cycle(3'b100, 3'b000, 3'b000, pack_a(3'd0, 3'd0, 3'd3), 6'd0);
        check_eq("abandon_idle", 32'(last_gnt), 32'b000);
        cycle(3'b100, 3'b000, 3'b000, pack_a(3'd0, 3'd0, 3'd3), 6'd0);
        check_eq("abandon_next", 32'(last_gnt), 32'b100);
        check_eq("abandon_busy", 32'(last_busy), 32'd0);

        // Decision unit holds the lock, backtrack must wait
        cycle(3'b100, 3'b100, 3'b100, pack_a(3'd0, 3'd0, 3'd2), 6'b01_00_00);
        cycle(3'b101, 3'b100, 3'b100, pack_a(3'd7, 3'd0, 3'd2), 6'b10_00_00);
        check_eq("nopreempt_1", 32'(last_gnt), 32'b100);
        cycle(3'b101, 3'b000, 3'b000, pack_a(3'd7, 3'd0, 3'd2), 6'd0);
        check_eq("nopreempt_2", 32'(last_gnt), 32'b100);
        cycle(3'b101, 3'b000, 3'b000, pack_a(3'd7, 3'd0, 3'd2), 6'd0);
        check_eq("nopreempt_bt", 32'(last_gnt), 32'b001);

        // Reset while a locked read burst is in flight
        cycle(3'b100, 3'b000, 3'b100, pack_a(3'd0, 3'd0, 3'd5), 6'd0);
        cycle(3'b100, 3'b000, 3'b100, pack_a(3'd0, 3'd0, 3'd6), 6'd0);
        check_eq("midlock_busy", 32'(bus.busy), 32'd1);
        check_eq("midlock_rvalid", 32'(bus.rvalid), 32'b100);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_gnt", 32'(bus.gnt), 32'd0);
        check_eq("arst_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("arst_fat_enable", 32'(bus.fat_enable), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(3'b110, 3'b000, 3'b000, pack_a(3'd0, 3'd1, 3'd5), 6'd0);
        check_eq("post_rst_gnt", 32'(last_gnt), 32'b010);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom), 3'($urandom), 3'($urandom) & 3'($urandom),
                  9'($urandom), 6'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
